// File: rtl/bpu_sram_pkg.sv
// rtl/bpu_sram_pkg.sv - shared state type and default geometry for the BPU table SRAM port
package bpu_sram_pkg;

    localparam int BPU_SRAM_DEPTH        = 128;
    localparam int BPU_SRAM_ADDR_W       = 7;
    localparam int BPU_SRAM_DATA_W       = 53;
    localparam int BPU_SRAM_STARVE_LIMIT = 4;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } port_state_t;

endpackage

// File: rtl/bpu_sram_port_ctrl.sv
// rtl/bpu_sram_port_ctrl.sv - zero-fill, write-priority arbitration and read return for one single-port BPU SRAM
module bpu_sram_port_ctrl
    import bpu_sram_pkg::*;
#(
    parameter int DEPTH        = BPU_SRAM_DEPTH,
    parameter int ADDR_W       = BPU_SRAM_ADDR_W,
    parameter int DATA_W       = BPU_SRAM_DATA_W,
    parameter int STARVE_LIMIT = BPU_SRAM_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              init_done,
    output logic              RW0_clk,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int CLR_W    = ADDR_W + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    port_state_t         state_q, state_d;
    logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                init_done_q;
    logic                rd_pend_q;
    logic [DATA_W-1:0]   hold_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                forced;
    logic                r_grant;
    logic                w_grant;

    assign RW0_clk      = clock;
    assign init_done    = init_done_q;
    assign r_resp_valid = rd_pend_q;
    // The macro output is only meaningful the cycle after a read; otherwise show the last captured word.
    assign r_resp_data  = rd_pend_q ? RW0_rdata : hold_q;

    // Next-state, arbitration and macro drive; address/data idle at their last values to avoid toggling.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        starve_cnt_d = starve_cnt_q;
        r_req_ready  = 1'b0;
        w_req_ready  = 1'b0;
        r_grant      = 1'b0;
        w_grant      = 1'b0;
        forced       = 1'b0;
        RW0_en       = 1'b0;
        RW0_wmode    = 1'b0;
        RW0_addr     = addr_q;
        RW0_wdata    = wdata_q;
        case (state_q)
            ST_CLEAR: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = clr_cnt_q[ADDR_W-1:0];
                RW0_wdata = '0;
                clr_cnt_d = clr_cnt_q + CLR_W'(1);
                if (clr_cnt_q == CLR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                forced = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
                if (forced) begin
                    r_req_ready = 1'b1;
                    w_req_ready = 1'b0;
                end else begin
                    w_req_ready = 1'b1;
                    r_req_ready = !w_req_valid;
                end
                r_grant = r_req_valid && r_req_ready;
                w_grant = w_req_valid && w_req_ready;
                if (w_grant) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b1;
                    RW0_addr  = w_req_addr;
                    RW0_wdata = w_req_data;
                end else if (r_grant) begin
                    RW0_en    = 1'b1;
                    RW0_wmode = 1'b0;
                    RW0_addr  = r_req_addr;
                end
                if (!r_req_valid || r_grant) begin
                    starve_cnt_d = '0;
                end else if (w_req_valid && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
                    starve_cnt_d = starve_cnt_q + STARVE_W'(1);
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // State, counters, in-flight read flag, held response and last macro address/data.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            starve_cnt_q <= '0;
            init_done_q  <= 1'b0;
            rd_pend_q    <= 1'b0;
            hold_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            init_done_q  <= (state_d == ST_IDLE);
            rd_pend_q    <= r_grant;
            if (rd_pend_q) begin
                hold_q <= RW0_rdata;
            end
            if (RW0_en) begin
                addr_q  <= RW0_addr;
                wdata_q <= RW0_wdata;
            end
        end
    end

endmodule
